// File: rtl/debug_pkg.sv
// Shared command codes, state encoding and sizing helpers for debug_unit.
package debug_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  localparam int WORD_BITS      = 32;
  localparam int BYTES_PER_WORD = WORD_BITS / 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CNT,
    LOAD_DATA,
    RUN,
    STEP,
    DUMP,
    ACK
  } state_t;

  function automatic int bytes_per_word(input int nbits);
    return nbits / 8;
  endfunction

endpackage

// File: rtl/tx_serializer.sv
// Sends one NBITS word LSB-first over a byte valid/ready handshake, or only its low
// byte when one_byte is set at start; done pulses the cycle after the last transfer.
module tx_serializer
  import debug_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             one_byte,
  input  logic [NBITS-1:0] word,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             done
);

  localparam int BPW   = bytes_per_word(NBITS);
  localparam int CBITS = $clog2(BPW);

  logic [NBITS-1:0] rest;
  logic [CBITS-1:0] left;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
      rest     <= '0;
      left     <= '0;
    end else begin
      done <= 1'b0;
      if (start && !tx_valid) begin
        tx_data  <= word[7:0];
        rest     <= word >> 8;
        left     <= one_byte ? '0 : CBITS'(BPW - 1);
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        // tx_data only moves after a completed handshake, so it is stable while stalled.
        if (left == '0) begin
          tx_valid <= 1'b0;
          done     <= 1'b1;
        end else begin
          tx_data <= rest[7:0];
          rest    <= rest >> 8;
          left    <= left - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_unit.sv
// Host debug controller: loads instruction memory, gates the pipeline in run/step mode
// and dumps the PC after each stop. Define DEBUG_REGDUMP_EN to also dump the register bank.
module debug_unit
  import debug_pkg::*;
#(
  parameter int MEM_SIZE  = 8,
  parameter int BANK_SIZE = 32,
  parameter int NBITS     = 32,
  parameter int RBITS     = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_imem_we,
  output logic [MEM_SIZE-1:0] o_imem_addr,
  output logic [NBITS-1:0]    o_imem_data,
  output logic                o_pipe_en,
  output logic                o_pipe_rst,
  input  logic                i_halt,
  input  logic [NBITS-1:0]    i_pc,
  output logic [RBITS-1:0]    o_reg_addr,
  input  logic [NBITS-1:0]    i_reg_data
);

  localparam int BPW   = bytes_per_word(NBITS);
  localparam int IBITS = $clog2(BPW);

  state_t              state;
  logic                pipe_en_q;
  logic                ser_start;
  logic                ser_one;
  logic                ser_done;
  logic                more_words;
  logic [IBITS-1:0]    byte_idx;
  logic [7:0]          words_left;
  logic [MEM_SIZE-1:0] load_addr;
  logic [NBITS-9:0]    pack;
  logic [NBITS-1:0]    dump_word;
  logic [NBITS-1:0]    ser_word;

  // NOTE: o_pipe_en is gated combinationally by i_halt so the pipeline never gets an
  // extra cycle once HALT retires; the registered half only says "we want to advance".
  assign o_pipe_en = pipe_en_q & ~i_halt;

  assign ser_one  = (state == ACK);
  assign ser_word = ser_one ? NBITS'(ACK_BYTE) : dump_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      o_imem_we   <= 1'b0;
      o_imem_addr <= '0;
      o_imem_data <= '0;
      o_pipe_rst  <= 1'b1;
      pipe_en_q   <= 1'b0;
      ser_start   <= 1'b0;
      byte_idx    <= '0;
      words_left  <= '0;
      load_addr   <= '0;
      pack        <= '0;
    end else begin
      // NOTE: strobes default low here and are raised below; with non-blocking
      // assignments the later assignment in the same cycle wins cleanly.
      o_imem_we <= 1'b0;
      ser_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: begin
                state      <= LOAD_CNT;
                o_pipe_rst <= 1'b1;
              end
              CMD_RUN: begin
                state      <= RUN;
                o_pipe_rst <= 1'b0;
                pipe_en_q  <= 1'b1;
              end
              CMD_STEP: begin
                state      <= STEP;
                o_pipe_rst <= 1'b0;
                pipe_en_q  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        LOAD_CNT: begin
          if (i_rx_valid) begin
            if (i_rx_data == 8'd0) begin
              state     <= ACK;
              ser_start <= 1'b1;
            end else begin
              words_left <= i_rx_data;
              load_addr  <= '0;
              byte_idx   <= '0;
              state      <= LOAD_DATA;
            end
          end
        end
        LOAD_DATA: begin
          if (i_rx_valid) begin
            // Little-endian: each new byte enters at the top and earlier ones shift down.
            pack <= {i_rx_data, pack[NBITS-9:8]};
            if (byte_idx == IBITS'(BPW - 1)) begin
              byte_idx    <= '0;
              o_imem_we   <= 1'b1;
              o_imem_addr <= load_addr;
              o_imem_data <= {i_rx_data, pack};
              load_addr   <= load_addr + 1'b1;
              words_left  <= words_left - 8'd1;
              if (words_left == 8'd1) begin
                state     <= ACK;
                ser_start <= 1'b1;
              end
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        RUN: begin
          if (i_halt) begin
            pipe_en_q <= 1'b0;
            state     <= DUMP;
            ser_start <= 1'b1;
          end
        end
        STEP: begin
          pipe_en_q <= 1'b0;
          state     <= DUMP;
          ser_start <= 1'b1;
        end
        DUMP: begin
          if (ser_done) begin
            if (more_words) ser_start <= 1'b1;
            else state <= IDLE;
          end
        end
        ACK: begin
          if (ser_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEBUG_REGDUMP_EN
  localparam int WBITS = $clog2(BANK_SIZE + 1);

  // Word 0 of a dump is the PC; word k (k >= 1) is register k-1.
  logic [WBITS-1:0] word_idx;

  assign more_words = (word_idx != WBITS'(BANK_SIZE));
  assign dump_word  = (word_idx == '0) ? i_pc : i_reg_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_idx   <= '0;
      o_reg_addr <= '0;
    end else if (state != DUMP) begin
      word_idx   <= '0;
      o_reg_addr <= '0;
    end else if (ser_done && more_words) begin
      word_idx   <= word_idx + 1'b1;
      o_reg_addr <= RBITS'(word_idx);
    end
  end
`else
  logic unused_reg_data;

  assign more_words      = 1'b0;
  assign dump_word       = i_pc;
  assign o_reg_addr      = '0;
  assign unused_reg_data = ^i_reg_data;
`endif

  tx_serializer #(
    .NBITS(NBITS)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (ser_start),
    .one_byte (ser_one),
    .word     (ser_word),
    .tx_data  (o_tx_data),
    .tx_valid (o_tx_valid),
    .tx_ready (i_tx_ready),
    .done     (ser_done)
  );

endmodule

// File: doc/debug_unit.md
# debug_unit

Host-side control stage sitting directly upstream of `datapath_pipe`. It receives command and data bytes from a UART receiver and loads program words into the pipeline's instruction memory. It gates the pipeline in run or single-step mode, and after each stop streams the PC (and, optionally, the register bank) back out through a UART transmitter.

## Interface
Parameters:
- `MEM_SIZE`, 8: instruction-memory address width in words (256 words).
- `BANK_SIZE`, 32: number of registers in the register bank.
- `NBITS`, 32: data/instruction word width.
- `RBITS`, 5: register address width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  8  received byte.
- `i_rx_valid`  in  1  one-cycle strobe; byte valid; no backpressure.
- `o_tx_data`  out  8  byte to transmit.
- `o_tx_valid`  out  1  transmit request.
- `i_tx_ready`  in  1  transmitter accepts byte when high together with `o_tx_valid`.
- `o_imem_we`  out  1  instruction-memory write strobe.
- `o_imem_addr`  out  MEM_SIZE  write word address.
- `o_imem_data`  out  NBITS  write word.
- `o_pipe_en`  out  1  pipeline clock-enable; pipeline advances one cycle per high cycle.
- `o_pipe_rst`  out  1  synchronous pipeline reset.
- `i_halt`  in  1  pipeline retired HALT; level, sticky until `o_pipe_rst`.
- `i_pc`  in  NBITS  current PC.
- `o_reg_addr`  out  RBITS  register-bank debug read address.
- `i_reg_data`  in  NBITS  combinational read data for `o_reg_addr`.

## Operation
- States: IDLE, LOAD_CNT, LOAD_DATA, RUN, STEP, DUMP, ACK.
- Reset values:
  - `o_tx_valid`=0, `o_tx_data`=0.
  - `o_imem_we`=0, `o_imem_addr`=0, `o_imem_data`=0.
  - `o_pipe_en`=0, `o_pipe_rst`=1, `o_reg_addr`=0.
  - State IDLE.
- IDLE commands (any other byte ignored):
  - 0x4C 'L' -> LOAD_CNT.
  - 0x52 'R' -> RUN.
  - 0x53 'S' -> STEP.
- LOAD_CNT:
  - Next byte is the word count N.
  - N=0 -> ACK.
  - Otherwise word index cleared -> LOAD_DATA.
  - `o_pipe_rst` held 1 through the whole load.
- LOAD_DATA:
  - Bytes arrive little-endian and are packed into an NBITS word.
  - On the 4th byte, `o_imem_we` pulses one cycle with addr = word index and data = the packed word.
  - Word index increments and wraps at 2^MEM_SIZE.
  - After N words -> ACK.
- ACK: sends 0x4B 'K', then returns to IDLE.
- RUN:
  - `o_pipe_rst`=0 and `o_pipe_en`=1 each cycle until `i_halt` is sampled high.
  - `o_pipe_en` drops the same cycle `i_halt` is seen, then -> DUMP.
  - If `i_halt` is already high on entry, zero enable cycles are issued.
- STEP:
  - `o_pipe_rst`=0; `o_pipe_en` high exactly one cycle (none if halted), then -> DUMP.
- DUMP:
  - Sends `i_pc` as 4 bytes, LSB first.
  - With the regdump feature: then registers 0..BANK_SIZE-1, 4 bytes each, LSB first, with `o_reg_addr` driving the current register.
  - Then -> IDLE.
- RX bytes arriving in RUN, STEP, DUMP or ACK are discarded.
- Reset mid-operation aborts everything:
  - A partial word is discarded.
  - No further `o_imem_we`.
  - `o_tx_valid` drops on the next cycle.

## Timing
- RX byte sampled on the cycle `i_rx_valid`=1.
- Command takes effect the next cycle.
- 4th data byte -> `o_imem_we` the next cycle.
- TX handshake: `o_tx_data` is stable while `o_tx_valid`=1; a byte transfers on a cycle with `o_tx_valid`&&`i_tx_ready`.
- The next byte is presented no earlier than the following cycle.
- DUMP length is 4 bytes, or 4+4*BANK_SIZE bytes with regdump.
- The STEP enable pulse occurs the cycle after the 'S' byte; DUMP starts the cycle after that.

## Configuration
- `DEBUG_REGDUMP_EN` defined: DUMP appends all registers after the PC; `o_reg_addr` is sequenced.
- `DEBUG_REGDUMP_EN` undefined: DUMP sends PC only (4 bytes); `o_reg_addr` is tied to 0.

## Structure
- Package `debug_pkg` holds:
  - command codes 0x4C/0x52/0x53;
  - ACK byte 0x4B;
  - state enum;
  - the bytes-per-word constant (NBITS/8).
- Sub-module `tx_serializer`: takes an NBITS word plus a start strobe, emits 4 bytes LSB-first over the valid/ready handshake, and returns done.

## Test plan
- 'L', 0x02, then bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE -> two `o_imem_we` pulses: addr0=0x12345678, addr1=0xDEADBEEF; then TX 0x4B.
- After load, 'S' -> exactly one `o_pipe_en` cycle; TX `i_pc` bytes (e.g. PC=0x4 -> 04,00,00,00), followed by the register stream when regdump is enabled.
- 'R' with `i_halt` raised after 10 cycles -> `o_pipe_en` high exactly 10 cycles, then DUMP.
- Byte 0x41 in IDLE -> no output activity; a following 'S' is still accepted.
- `rst` after 2 bytes of a load word -> no `o_imem_we`; state IDLE; `o_pipe_rst`=1.
- `i_tx_ready` low for 5 cycles during DUMP -> `o_tx_data` unchanged; no byte lost or duplicated.
